// File: rtl/case_cmd_encoder_if.sv
// case_cmd_encoder_if
//   Handshake bundle between an upstream character source, the encoder and
//   the downstream control/transform block.
//   Upstream side : inValid, inReady, inData[7:0], inMode[1:0]
//   Downstream side: outValid, outReady, outData[7:0]
//   modport master : the environment (drives characters and outReady)
//   modport slave  : the encoder
interface case_cmd_encoder_if;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic [1:0] inMode;
  logic       outValid;
  logic       outReady;
  logic [7:0] outData;

  modport master (
    output inValid, inData, inMode, outReady,
    input  inReady, outValid, outData
  );

  modport slave (
    input  inValid, inData, inMode, outReady,
    output inReady, outValid, outData
  );
endinterface

// File: rtl/case_cmd_encoder.sv
// case_cmd_encoder
//   Turns a stream of (character, case mode) pairs into a byte stream for the
//   case-transform receiver. A mode change inserts ESC (0x1B) + command letter
//   (N=0x4E L=0x4C U=0x55 C=0x43) before the character. A literal ESC is
//   followed by a redundant letter for the current mode so every ESC on the
//   wire is always followed by a legal command.
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   bus (slave)   inValid/inReady/inData/inMode upstream,
//                 outValid/outReady/outData downstream (single output register)
//   curMode       receiver mode once every emitted byte has been consumed
//   busy          high while the FSM is outside IDLE
// Optional feature macro: CASE_ENC_RESYNC_EN
//   When defined, after RESYNC_PERIOD data bytes without a command letter the
//   next same-mode character is preceded by ESC + letter(curMode).
module case_cmd_encoder #(
  parameter int RESYNC_PERIOD = 16,
  parameter int CNT_W         = 5
) (
  input  logic                clock,
  input  logic                reset,
  case_cmd_encoder_if.slave   bus,
  output logic [1:0]          curMode,
  output logic                busy
);

  localparam logic [7:0] ESC = 8'h1B;

  typedef enum logic [1:0] {IDLE, CMD, CHAR, FIX} state_t;

  if ((2 ** CNT_W) <= RESYNC_PERIOD) begin : g_cfg_check
    $error("case_cmd_encoder: CNT_W too narrow for RESYNC_PERIOD");
  end

  state_t     state_q, state_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d;
  logic [1:0] cur_mode_q, cur_mode_d;
  logic [7:0] pend_char_q, pend_char_d;
  logic [1:0] pend_mode_q, pend_mode_d;

  logic slot_free;
  logic in_ready;
  logic accept;
  logic resync;
  logic cmd_needed;

  function automatic logic [7:0] letter(input logic [1:0] m);
    case (m)
      2'd0:    letter = 8'h4E;
      2'd1:    letter = 8'h4C;
      2'd2:    letter = 8'h55;
      default: letter = 8'h43;
    endcase
  endfunction

  assign slot_free  = !out_valid_q || bus.outReady;
  assign in_ready   = reset && (state_q == IDLE) && slot_free;
  assign accept     = bus.inValid && in_ready;
  assign cmd_needed = (bus.inMode != cur_mode_q) || resync;

`ifdef CASE_ENC_RESYNC_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_data;
  logic             load_letter;

  assign resync      = (cnt_q == CNT_W'(RESYNC_PERIOD));
  // Counter bookkeeping derived from the same load conditions the FSM uses,
  // so the FSM body is identical in both builds.
  assign load_letter = slot_free && ((state_q == CMD) || (state_q == FIX));
  assign load_data   = (slot_free && (state_q == CHAR)) || (accept && !cmd_needed);

  always_comb begin
    cnt_d = cnt_q;
    if (load_letter)    cnt_d = '0;
    else if (load_data) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign resync = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    cur_mode_d  = cur_mode_q;
    pend_char_d = pend_char_q;
    pend_mode_d = pend_mode_q;
    // A free slot means the current byte (if any) leaves this cycle.
    out_valid_d = slot_free ? 1'b0 : out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          if (cmd_needed) begin
            out_data_d  = ESC;
            pend_char_d = bus.inData;
            pend_mode_d = bus.inMode;
            state_d     = CMD;
          end else if (bus.inData == ESC) begin
            out_data_d = ESC;
            state_d    = FIX;
          end else begin
            out_data_d = bus.inData;
          end
        end
      end
      CMD: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = letter(pend_mode_q);
          cur_mode_d  = pend_mode_q;
          state_d     = CHAR;
        end
      end
      CHAR: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = pend_char_q;
          state_d     = (pend_char_q == ESC) ? FIX : IDLE;
        end
      end
      FIX: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = letter(cur_mode_q);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cur_mode_q  <= '0;
      pend_char_q <= '0;
      pend_mode_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cur_mode_q  <= cur_mode_d;
      pend_char_q <= pend_char_d;
      pend_mode_q <= pend_mode_d;
    end
  end

  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid_q;
  assign bus.outData  = out_data_q;
  assign curMode      = cur_mode_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_case_cmd_encoder.sv
module tb_case_cmd_encoder;

  localparam int RESYNC_PERIOD = 16;

  logic       clock;
  logic       reset;
  logic [1:0] curMode;
  logic       busy;

  case_cmd_encoder_if bus ();

  case_cmd_encoder #(
    .RESYNC_PERIOD (RESYNC_PERIOD),
    .CNT_W         (5)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus.slave),
    .curMode (curMode),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: the list of bytes the receiver must see, plus the mode
  // the receiver ends up in and the number of characters since the last
  // command letter.
  logic [7:0] exp_q[$];
  logic [1:0] m_cur = 2'd0;
  int unsigned m_since_cmd = 0;

  function automatic logic [7:0] cmd_letter(input logic [1:0] m);
    case (m)
      2'd0:    return 8'h4E;
      2'd1:    return 8'h4C;
      2'd2:    return 8'h55;
      default: return 8'h43;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
  endtask

  task automatic model_accept(input logic [7:0] d, input logic [1:0] m);
    bit force_cmd;
    force_cmd = 1'b0;
`ifdef CASE_ENC_RESYNC_EN
    force_cmd = (m_since_cmd == RESYNC_PERIOD);
`endif
    if (m != m_cur || force_cmd) begin
      exp_q.push_back(8'h1B);
      exp_q.push_back(cmd_letter(m));
      exp_q.push_back(d);
      m_cur = m;
      if (d == 8'h1B) begin
        exp_q.push_back(cmd_letter(m));
        m_since_cmd = 0;
      end else begin
        m_since_cmd = 1;
      end
    end else if (d == 8'h1B) begin
      exp_q.push_back(8'h1B);
      exp_q.push_back(cmd_letter(m_cur));
      m_since_cmd = 0;
    end else begin
      exp_q.push_back(d);
      m_since_cmd++;
    end
  endtask

  // One clock: observe handshakes mid-cycle, then advance to just past the edge.
  task automatic step();
    @(negedge clock);
    if (bus.outValid && bus.outReady) begin
      chk("sb_nonempty", 8'(exp_q.size() != 0), 8'd1);
      if (exp_q.size() != 0) chk("sb_byte", bus.outData, exp_q.pop_front());
    end
    if (bus.inValid && bus.inReady) model_accept(bus.inData, bus.inMode);
    @(posedge clock);
    #1;
  endtask

  // Send one character with outReady high and check the literal byte sequence
  // (first byte in the top octet) together with inReady per output cycle.
  task automatic send_expect(input logic [7:0] d, input logic [1:0] m,
                             input logic [31:0] seq, input int unsigned n);
    bus.inValid = 1'b1;
    bus.inData  = d;
    bus.inMode  = m;
    step();
    bus.inValid = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      chk("seq_byte", bus.outData, seq[31-8*i -: 8]);
      chk("seq_valid", 8'(bus.outValid), 8'd1);
      chk("seq_inready", 8'(bus.inReady), 8'(i == n - 1));
      step();
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus.inValid  = 1'b0;
    bus.inData   = '0;
    bus.inMode   = '0;
    bus.outReady = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_inready", 8'(bus.inReady), 8'd0);
    chk("rst_outvalid", 8'(bus.outValid), 8'd0);
    chk("rst_outdata", bus.outData, 8'h00);
    chk("rst_curmode", 8'(curMode), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_inready", 8'(bus.inReady), 8'd1);
    chk("post_rst_curmode", 8'(curMode), 8'd0);

    // Plain character in the current mode
    send_expect(8'h61, 2'd0, 32'h6100_0000, 1);

    // Mode change N -> L, with curMode moving on the letter load
    bus.inValid = 1'b1; bus.inData = 8'h78; bus.inMode = 2'd1;
    step();
    bus.inValid = 1'b0;
    chk("chg_b0", bus.outData, 8'h1B);
    chk("chg_b0_inready", 8'(bus.inReady), 8'd0);
    chk("chg_b0_busy", 8'(busy), 8'd1);
    chk("chg_b0_curmode", 8'(curMode), 8'd0);
    step();
    chk("chg_b1", bus.outData, 8'h4C);
    chk("chg_b1_inready", 8'(bus.inReady), 8'd0);
    chk("chg_b1_curmode", 8'(curMode), 8'd1);
    step();
    chk("chg_b2", bus.outData, 8'h78);
    chk("chg_b2_inready", 8'(bus.inReady), 8'd1);
    chk("chg_b2_busy", 8'(busy), 8'd0);
    step();

    // Literal ESC handling in U, then ESC with a change to C
    send_expect(8'h70, 2'd2, 32'h1B55_7000, 3);
    send_expect(8'h1B, 2'd2, 32'h1B55_0000, 2);
    chk("esc_curmode_u", 8'(curMode), 8'd2);
    send_expect(8'h1B, 2'd3, 32'h1B43_1B43, 4);
    chk("esc_curmode_c", 8'(curMode), 8'd3);

    // Backpressure on the ESC of a mode change
    bus.inValid = 1'b1; bus.inData = 8'h79; bus.inMode = 2'd1;
    step();
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_data", bus.outData, 8'h1B);
      chk("bp_hold_valid", 8'(bus.outValid), 8'd1);
      step();
    end
    bus.outReady = 1'b1;
    chk("bp_release_b0", bus.outData, 8'h1B);
    step();
    chk("bp_b1", bus.outData, 8'h4C);
    step();
    chk("bp_b2", bus.outData, 8'h79);
    step();

    // Reset while a command is in flight
    bus.inValid = 1'b1; bus.inData = 8'h7A; bus.inMode = 2'd0;
    step();
    bus.inValid = 1'b0;
    chk("mid_cmd_busy", 8'(busy), 8'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_outvalid", 8'(bus.outValid), 8'd0);
    chk("mid_rst_curmode", 8'(curMode), 8'd0);
    chk("mid_rst_inready", 8'(bus.inReady), 8'd0);
    exp_q.delete();
    m_cur = 2'd0;
    m_since_cmd = 0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    send_expect(8'h62, 2'd0, 32'h6200_0000, 1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      bus.inValid  = ($urandom_range(0, 3) != 0);
      bus.inData   = ($urandom_range(0, 4) == 0) ? 8'h1B : 8'($urandom);
      bus.inMode   = ($urandom_range(0, 2) == 0) ? 2'($urandom) : m_cur;
      bus.outReady = ($urandom_range(0, 9) < 7);
      step();
    end
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.outValid); i++) step();
    chk("drain_empty", 8'(exp_q.size()), 8'd0);
    chk("drain_outvalid", 8'(bus.outValid), 8'd0);
    chk("drain_curmode", 8'(curMode), 8'(m_cur));
    chk("drain_busy", 8'(busy), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/case_cmd_encoder.md
Name: case_cmd_encoder

Overview:
- Transmit-side companion to the case-transform datapath.
- Accepts a stream of characters, each tagged with a requested case mode (Normal/Lower/Upper/Change).
- Emits a byte stream for the downstream control/transform block. Whenever the requested mode changes, it inserts a two-byte command (ESC 0x1B followed by a command letter).
- Guarantees every ESC on the wire is followed by a legal command letter, so the receiver's command lines never go undefined.

Parameters:
- RESYNC_PERIOD, 16: characters emitted without a command byte before a forced resync (used only with the optional feature).
- CNT_W, 5: width of the resync counter; must satisfy 2^CNT_W > RESYNC_PERIOD.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- inValid  input  1  upstream character valid
- inReady  output  1  character accepted when inValid && inReady at a rising clock edge
- inData  input  8  character byte
- inMode  input  2  requested mode: 0=N, 1=L, 2=U, 3=C
- outValid  output  1  outData holds a byte for downstream
- outReady  input  1  downstream accepts when outValid && outReady
- outData  output  8  encoded byte stream
- curMode  output  2  mode the receiver is in once all emitted bytes are consumed
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, outValid=0, outData=0x00, curMode=0 (N), pending char/mode cleared, resync counter=0.
  - inReady=0 while reset is low.
  - curMode resets to N, matching the receiver's reset state (Ncmd=1).
- Output stage:
  - One output register. slotFree = !outValid || outReady.
  - outData and outValid hold stable while outValid && !outReady.
  - outValid drops the cycle after a handshake unless a new byte loads in the same cycle.
- inReady = reset && (state==IDLE) && slotFree. This is combinational from state and outValid/outReady.
- Command letters: N=0x4E, L=0x4C, U=0x55, C=0x43.
- FSM states: IDLE, CMD, CHAR, FIX.
- IDLE, on accept:
  - If inMode != curMode: load 0x1B, latch pendChar=inData and pendMode=inMode, go to CMD.
  - Else if inData == 0x1B: load 0x1B, go to FIX.
  - Else: load inData and stay in IDLE. Throughput is 1 byte/cycle with no bubble.
- CMD, when slotFree: load letter(pendMode), set curMode=pendMode in the same cycle, go to CHAR.
- CHAR, when slotFree: load pendChar; go to FIX if pendChar==0x1B, else go to IDLE.
- FIX, when slotFree: load letter(curMode), go to IDLE. This emits a redundant command that keeps the receiver's mode intact.
- Latency: an accepted byte is on outData the following cycle. A mode change adds 2 bytes (3 output cycles total, with inReady low for 2 cycles).
- Worst case: a literal ESC that also changes mode emits 4 bytes: 1B, letter, 1B, letter.
- Backpressure in any state stalls the FSM in place. No byte is dropped or duplicated.
- Reset asserted mid-sequence: any partial command is discarded immediately and outValid falls asynchronously. The system relies on the receiver resetting concurrently.
- inMode and inData are sampled only at accept. Changes while inReady=0 are ignored.

Optional Feature:
- Macro: CASE_ENC_RESYNC_EN.
- Defined:
  - Counter increments on each data byte loaded in IDLE or CHAR. It clears on every letter byte loaded (CMD or FIX).
  - In IDLE, when counter == RESYNC_PERIOD, a same-mode accept is treated as a mode change. The encoder emits 0x1B, letter(curMode), then the char, using the CMD/CHAR path.
- Undefined:
  - No counter logic exists.
  - Commands are emitted only on a real mode change or a literal ESC.
  - Output is bit-identical to the defined build for streams that never reach RESYNC_PERIOD.

Test Plan:
- After reset: inReady=1, curMode=0. Send 0x61 in mode N with outReady=1 -> outData=0x61 one cycle later, busy stays 0.
- From N, send 0x78 in mode L -> outData 0x1B, 0x4C, 0x78 on consecutive cycles; inReady low 2 cycles; curMode=1 from the 0x4C load.
- In mode U, send literal 0x1B -> outData 0x1B, then 0x55; curMode stays 2. Then send 0x1B in mode C -> 0x1B, 0x43, 0x1B, 0x43.
- Mode change with outReady held low 5 cycles at the 0x1B byte -> outData=0x1B stable for 5 cycles, then 0x4C and the char; no loss or duplication.
- Pull reset low while in CMD state -> outValid=0 and curMode=0 immediately. After release, 0x62 in mode N -> emitted directly as 0x62.
- With CASE_ENC_RESYNC_EN and RESYNC_PERIOD=4: send 0x41..0x45 in mode L after the initial switch -> 1B 4C 41 42 43 44 1B 4C 45.
